// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with parallel load, wrap pulse and a
// time-multiplexed digit scan for an external 7-segment display.
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count,
    output logic        tc,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  an
);

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DW     = 4;
    localparam int unsigned IW     = 2;
    localparam int unsigned PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic [DW-1:0] digit_q [DIGITS];
    logic [DW-1:0] step_d  [DIGITS];
    logic [DW-1:0] load_d  [DIGITS];
    logic          wrap_c;
    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt_c;

    // Ripple carry/borrow across the digits; a carry out of digit 3 is a wrap.
    always_comb begin : step_logic
        logic carry;
        carry  = 1'b1;
        wrap_c = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            step_d[k] = digit_q[k];
            load_d[k] = (load_val[k*DW +: DW] > 4'd9) ? 4'd0 : load_val[k*DW +: DW];
            if (carry) begin
                if (up_dn) begin
                    if (digit_q[k] == 4'd9) begin
                        step_d[k] = 4'd0;
                    end else begin
                        step_d[k] = digit_q[k] + 4'd1;
                        carry     = 1'b0;
                    end
                end else begin
                    if (digit_q[k] == 4'd0) begin
                        step_d[k] = 4'd9;
                    end else begin
                        step_d[k] = digit_q[k] - 4'd1;
                        carry     = 1'b0;
                    end
                end
            end
        end
        wrap_c = carry;
    end

    assign idx_nxt_c = idx_q + IW'(1);

    // Counter digits and terminal-count pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_q[k] <= '0;
            end
            tc <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_q[k] <= load_d[k];
            end
            tc <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_q[k] <= step_d[k];
            end
            tc <= wrap_c;
        end else begin
            tc <= 1'b0;
        end
    end

    // Scan prescaler and digit index; free-running, unaffected by load/en.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            an    <= 4'b1110;
        end else if (pre_q == PRE_MAX) begin
            pre_q <= '0;
            idx_q <= idx_nxt_c;
            an    <= ~(4'b0001 << idx_nxt_c);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    assign count     = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
    assign digit_bcd = digit_q[idx_q];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter: a behavioural model pushes the
// expected post-edge outputs, which are popped and compared after each edge.
module tb_bcd_scan_counter;

    localparam int unsigned SD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count, count1;
    logic        tc, tc1;
    logic [3:0]  digit_bcd, digit_bcd1, an, an1;

    always #5 clk = ~clk;

    bcd_scan_counter #(.SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .tc(tc),
        .digit_bcd(digit_bcd), .an(an)
    );

    bcd_scan_counter #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1),
        .digit_bcd(digit_bcd1), .an(an1)
    );

    typedef struct {
        logic [15:0] count;
        logic        tc;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic [3:0]  an1;
        logic [3:0]  dig1;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    int m_val = 0;
    int m_tc  = 0;
    int m_pre = 0;
    int m_idx = 0;
    int m_idx1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd_to_int(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3:0] sel_digit(input logic [15:0] b, input int idx);
        logic [15:0] s;
        s = b >> (4 * idx);
        return s[3:0];
    endfunction

    // Drive one cycle, update the model, and check the DUT after the edge.
    task automatic step(input logic r, input logic ld, input logic [15:0] lv,
                        input logic e, input logic ud);
        exp_t x, y;
        logic [15:0] lvs;
        @(negedge clk);
        reset = r; load = ld; load_val = lv; en = e; up_dn = ud;
        if (r) begin
            m_val = 0; m_tc = 0; m_pre = 0; m_idx = 0; m_idx1 = 0;
        end else begin
            if (ld) begin
                lvs = lv;
                for (int k = 0; k < 4; k++)
                    if (lvs[4*k +: 4] > 4'd9) lvs[4*k +: 4] = 4'd0;
                m_val = bcd_to_int(lvs);
                m_tc  = 0;
            end else if (e) begin
                if (ud) begin
                    m_tc  = (m_val == 9999) ? 1 : 0;
                    m_val = (m_val + 1) % 10000;
                end else begin
                    m_tc  = (m_val == 0) ? 1 : 0;
                    m_val = (m_val + 9999) % 10000;
                end
            end else begin
                m_tc = 0;
            end
            if (m_pre == SD - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
            m_idx1 = (m_idx1 + 1) % 4;
        end
        x.count = int_to_bcd(m_val);
        x.tc    = 1'(m_tc);
        x.an    = 4'(~(32'd1 << m_idx));
        x.dig   = sel_digit(x.count, m_idx);
        x.an1   = 4'(~(32'd1 << m_idx1));
        x.dig1  = sel_digit(x.count, m_idx1);
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            y = q.pop_front();
            chk("count",  32'(count),      32'(y.count));
            chk("tc",     32'(tc),         32'(y.tc));
            chk("an",     32'(an),         32'(y.an));
            chk("digit",  32'(digit_bcd),  32'(y.dig));
            chk("count1", 32'(count1),     32'(y.count));
            chk("tc1",    32'(tc1),        32'(y.tc));
            chk("an1",    32'(an1),        32'(y.an1));
            chk("digit1", 32'(digit_bcd1), 32'(y.dig1));
        end
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("rst_count", 32'(count), 32'h0000);
        chk("rst_an",    32'(an),    32'hE);
        chk("rst_tc",    32'(tc),    32'h0);

        // Ten increments
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("ten_up", 32'(count), 32'h0010);

        // Up wrap from 9998
        step(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("up_9999", 32'(count), 32'h9999);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("up_wrap_tc", 32'(tc), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("tc_one_cycle", 32'(tc), 32'h0);

        // Down wrap from 0000; loads never pulse tc
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        chk("load0_tc", 32'(tc), 32'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("dn_wrap", 32'(count), 32'h9999);
        chk("dn_wrap_tc", 32'(tc), 32'h1);
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
        chk("load9999_tc", 32'(tc), 32'h0);

        // Load wins over en; invalid nibbles cleared
        step(1'b0, 1'b1, 16'h1A3F, 1'b1, 1'b1);
        chk("load_sanitize", 32'(count), 32'h1030);

        // Scan of a held value
        step(1'b0, 1'b1, 16'h4321, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset in the middle of a run at scan index 2
        for (int i = 0; i < 8 && m_idx != 2; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("reached_idx2", 32'(m_idx), 32'd2);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("midrst_count", 32'(count), 32'h0000);
        chk("midrst_an",    32'(an),    32'hE);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        chk("resume", 32'(count), 32'h0001);

        // Random traffic with direction changes, occasional loads and resets
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) == 0),
                 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        // Force a couple of wraps through the random path's model too
        step(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit is held on the scan outputs (legal range 1..65535).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 en  input  1  count enable; one count step per cycle while high.
REQ-005 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 load_val  input  16  four BCD digits to load; [15:12] = digit 3 (most significant) ... [3:0] = digit 0.
REQ-008 count  output  16  current four-digit BCD value, same packing as load_val.
REQ-009 tc  output  1  terminal-count pulse on wrap-around.
REQ-010 digit_bcd  output  4  BCD digit currently scanned; bit 3 = MSB, drives the downstream 7-segment decoder (bit 3 -> I0, bit 0 -> I3).
REQ-011 an  output  4  active-low one-hot digit enable; an[k] = 0 selects digit k.

Function
REQ-012 Counter state: four 4-bit digit registers, each always holding 0..9.
REQ-013 Priority per cycle: reset > load > en; en ignored in any cycle where load = 1.
REQ-014 load = 1: each nibble of load_val is written to its digit; any nibble > 9 is written as 0; the other nibbles are unaffected.
REQ-015 en = 1, up_dn = 1: BCD increment; a digit at 9 becomes 0 and carries into the next higher digit; 9999 -> 0000.
REQ-016 en = 1, up_dn = 0: BCD decrement; a digit at 0 becomes 9 and borrows from the next higher digit; 0000 -> 9999.
REQ-017 en = 0 and load = 0: count holds its value.
REQ-018 Latency: count reflects a load or step on the clock edge that samples the request (one cycle); count is a registered output.
REQ-019 tc is registered and goes high for exactly one cycle after the edge on which a 9999 -> 0000 (up) or 0000 -> 9999 (down) step occurs; otherwise 0.
REQ-020 A load never asserts tc, including a load of 0000 or 9999.
REQ-021 up_dn may change on any cycle; each step uses the up_dn value sampled on that edge.
REQ-022 Scan prescaler: counts 0..SCAN_DIV-1 each cycle, independent of en/load; at SCAN_DIV-1 it returns to 0 and the scan index advances 0->1->2->3->0.
REQ-023 SCAN_DIV = 1: the scan index advances every cycle.
REQ-024 an = ~(4'b0001 << index), registered; exactly one bit is low at all times.
REQ-025 digit_bcd = count digit[index]; combinational from the digit and index registers, so a count change appears on digit_bcd in the same cycle as on count.
REQ-026 load and scanning are independent: a load does not reset the prescaler or the index.

Reset
REQ-027 On reset: count = 16'h0000, tc = 0, prescaler = 0, index = 0, an = 4'b1110, digit_bcd = 4'h0.
REQ-028 Reset asserted mid-count or mid-scan overrides load/en in the same cycle; the first count step after reset release occurs on the first edge with reset = 0 and en = 1.

Verification
REQ-029 reset 1 cycle, then en=1, up_dn=1 for 10 cycles -> count = 16'h0010; tc stays 0.
REQ-030 load load_val=16'h9998, then en=1, up_dn=1 for 2 cycles -> count 9999, then 0000; tc high for exactly the one cycle after the wrap edge.
REQ-031 load 16'h0000 with tc checked, then en=1, up_dn=0 -> tc stays 0 during the load; count = 16'h9999 and a 1-cycle tc pulse after the step.
REQ-032 load=1 with en=1 and load_val=16'h1A3F -> count = 16'h1030 (invalid nibbles forced to 0); no step applied that cycle.
REQ-033 SCAN_DIV=4, count=16'h4321, en=0 for 16 cycles -> an cycles 1110, 1101, 1011, 0111, each held 4 cycles; digit_bcd = 1, 2, 3, 4 respectively.
REQ-034 reset asserted for 1 cycle during a run with en=1 and index=2 -> the next cycle shows count=0000, an=1110, tc=0; counting resumes from 0001.
